// File: rtl/ex_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for port hookup.
interface ex_if #(parameter int WIDTH = 32);
  logic             hit;
  logic [1:0]       WB;
  logic [2:0]       M;
  logic [3:0]       EX;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] readdat1;
  logic [WIDTH-1:0] readdat2;
  logic [WIDTH-1:0] signext;
  logic [4:0]       instr_2016;
  logic [4:0]       instr_1511;
  logic [1:0]       WBout;
  logic [2:0]       Mout;
  logic [WIDTH-1:0] branch_target;
  logic             zero;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] wdata;
  logic [4:0]       wreg;
  logic             stall;

  modport master (
    output hit, WB, M, EX, npc, readdat1, readdat2, signext, instr_2016, instr_1511,
    input  WBout, Mout, branch_target, zero, alu_result, wdata, wreg, stall
  );

  modport slave (
    input  hit, WB, M, EX, npc, readdat1, readdat2, signext, instr_2016, instr_1511,
    output WBout, Mout, branch_target, zero, alu_result, wdata, wreg, stall
  );
endinterface

// File: rtl/ex_stage.sv
// MiniCore execute stage: ALU, branch target and EX/MEM register; one-cycle latency, hit=0 freezes.
// Define EX_MUL_EN to add the iterative shift-add multiplier, which stalls upstream for WIDTH cycles.
module ex_stage #(
  parameter int          WIDTH     = 32,
  parameter logic [5:0]  MUL_FUNCT = 6'h18
) (
  input logic  clk,
  input logic  rst,
  ex_if.slave  bus
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] res_val;
  logic [5:0]       funct;
  logic [1:0]       alu_op;
  logic             lt;
  logic             bubble;

  assign op_a   = bus.readdat1;
  assign op_b   = bus.EX[0] ? bus.signext : bus.readdat2;
  assign funct  = bus.signext[5:0];
  assign alu_op = bus.EX[2:1];
  assign lt     = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      default: begin
        case (funct)
          6'h20:   alu_res = op_a + op_b;
          6'h22:   alu_res = op_a - op_b;
          6'h24:   alu_res = op_a & op_b;
          6'h25:   alu_res = op_a | op_b;
          6'h2A:   alu_res = {{(WIDTH-1){1'b0}}, lt};
          default: alu_res = '0;
        endcase
      end
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] acc_sum;
  logic             is_mul;
  logic             stall_c;

  assign is_mul  = (alu_op == 2'b10) && (funct == MUL_FUNCT);
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (bus.hit) begin
      state  <= state_nxt;
      count  <= count_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
    end
  end

  // The count==0 edge still performs the last add, so acc_sum is the finished product.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    stall_c    = 1'b0;
    bubble     = 1'b0;
    res_val    = alu_res;
    case (state)
      IDLE: begin
        if (is_mul) begin
          stall_c    = 1'b1;
          bubble     = 1'b1;
          state_nxt  = BUSY;
          mcand_nxt  = op_a;
          mplier_nxt = op_b;
          acc_nxt    = '0;
          count_nxt  = CW'(WIDTH - 1);
        end
      end
      BUSY: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count - CW'(1);
        if (count != '0) begin
          stall_c = 1'b1;
          bubble  = 1'b1;
        end else begin
          res_val   = acc_sum;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.stall = rst & stall_c;
`else
  logic unused_mul_funct;
  assign unused_mul_funct = ^MUL_FUNCT;
  assign bubble    = 1'b0;
  assign res_val   = alu_res;
  assign bus.stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.WBout         <= '0;
      bus.Mout          <= '0;
      bus.branch_target <= '0;
      bus.zero          <= 1'b0;
      bus.alu_result    <= '0;
      bus.wdata         <= '0;
      bus.wreg          <= '0;
    end else if (bus.hit) begin
      if (bubble) begin
        bus.WBout <= '0;
        bus.Mout  <= '0;
      end else begin
        bus.WBout         <= bus.WB;
        bus.Mout          <= bus.M;
        bus.branch_target <= bus.npc + (bus.signext << 2);
        bus.zero          <= (res_val == '0);
        bus.alu_result    <= res_val;
        bus.wdata         <= bus.readdat2;
        bus.wreg          <= bus.EX[3] ? bus.instr_1511 : bus.instr_2016;
      end
    end
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the MiniCore 5-stage pipeline.
- Consumes the ID/EX register outputs and computes the ALU result, branch target and zero flag.
- Selects the destination register and registers everything into the EX/MEM boundary feeding the MEM stage.
- Contains an iterative shift-add multiplier. While the multiplier is busy, the stage stalls the upstream stages.

Parameters:
- WIDTH, 32: datapath width; also the number of multiply iterations.
- MUL_FUNCT, 6'h18: funct code selecting multiply when ALUOp=2'b10.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- hit  in  1  cache hit; 0 freezes the whole stage (registers, FSM, counter)
- WB  in  2  WB controls from ID/EX
- M  in  3  memory controls from ID/EX (bit0 branch, bit1 memread, bit2 memwrite)
- EX  in  4  EX[3]=RegDst, EX[2:1]=ALUOp, EX[0]=ALUSrc
- npc  in  WIDTH  PC+4
- readdat1  in  WIDTH  rs operand
- readdat2  in  WIDTH  rt operand
- signext  in  WIDTH  sign-extended immediate; funct = signext[5:0]
- instr_2016  in  5  rt field
- instr_1511  in  5  rd field
- WBout  out  2  registered WB
- Mout  out  3  registered M
- branch_target  out  WIDTH  npc + (signext<<2), registered
- zero  out  1  alu_result==0, registered
- alu_result  out  WIDTH  registered result
- wdata  out  WIDTH  registered readdat2 (store data)
- wreg  out  5  registered destination: RegDst ? instr_1511 : instr_2016
- stall  out  1  combinational; upstream holds ID/EX and PC while high

Behaviour:
- Reset (rst=0, async): all outputs and registers 0, FSM=IDLE, count=0; stall=0 while in reset.
- Operand B = ALUSrc ? signext : readdat2.
- ALUOp 00: add. ALUOp 01: sub. ALUOp 11: OR.
- ALUOp 10 decodes funct:
  - 20 add, 22 sub, 24 AND, 25 OR
  - 2A slt (signed; result 1 or 0)
  - MUL_FUNCT multiply
  - any other funct: result 0
- Arithmetic is WIDTH bits; overflow wraps with no trap. Multiply keeps the low WIDTH bits of the unsigned product.
- Non-multiply ops: one-cycle latency; all outputs captured at the next posedge when hit=1.
- FSM states: IDLE, BUSY.
- IDLE with a multiply at the input (is_mul):
  - stall=1 combinationally.
  - On the edge: latch operands (mcand=A, mplier=B), acc=0, count=WIDTH-1, go to BUSY.
  - EX/MEM receives a bubble: WBout=0, Mout=0; other outputs don't-care but are held.
- BUSY, each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count -= 1.
  - stall = (count != 0).
  - While count != 0, EX/MEM receives a bubble each edge.
- BUSY with count==0 (final iteration, stall=0):
  - The edge writes the final acc to alu_result and captures WB/M/wreg/wdata/branch_target from the still-held inputs.
  - zero reflects the product; return to IDLE.
  - Upstream advances on the same edge.
- Multiply timing: occupies EX for WIDTH+1 cycles; stall is high for exactly WIDTH cycles.
- hit=0: no register, FSM or counter changes. stall keeps its combinational value.
- Reset mid-multiply: FSM returns to IDLE immediately, partial product is discarded, stall drops.
- A multiply arriving in the cycle right after a multiply completes starts a new sequence normally.

Optional Feature:
- EX_MUL_EN defined: multiplier and FSM as above.
- Undefined: no FSM or multiplier logic. MUL_FUNCT decodes as an unknown funct (result 0, one-cycle latency) and stall is tied to 0.

Test Plan:
- add: readdat1=5, readdat2=7, ALUOp=10, funct=20, RegDst=1, rd=3 -> next edge alu_result=12, zero=0, wreg=3, WBout/Mout equal the inputs.
- beq compare: ALUOp=01, A=B=9, M=001, npc=0x100, signext=4 -> alu_result=0, zero=1, branch_target=0x110.
- slt signed: A=0xFFFFFFFF, B=1, funct=2A -> alu_result=1. With A=1, B=0xFFFFFFFF -> 0.
- mul: A=7, B=6, funct=18, inputs held while stall=1:
  - stall high for exactly 32 cycles; bubbles (WBout=0, Mout=0) during that window.
  - On the 33rd edge: alu_result=42, WBout=input WB.
  - Then A=0x10000, B=0x10000 -> alu_result=0, zero=1.
- hit freeze: start mul, drop hit for 5 cycles mid-sequence -> all outputs and count hold; total stall-high cycles = 37; result still 42.
- Reset mid-mul: assert rst=0 at iteration 10 -> outputs 0 and stall=0 immediately. After release, an add 2+2 gives 4 in one cycle.
